serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial adder stage that drives the Half_Adder cell directly. Two Half_Adder instances plus an OR gate form a one-bit full-adder slice, and a registered carry loop sits around that slice. Two WIDTH-bit operands are loaded on a start pulse and added LSB-first, one bit per clock. The block delivers a registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It trades latency for area in datapaths that cannot afford a WIDTH-bit ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A; sampled on accepted start
B  input  WIDTH  operand B; sampled on accepted start
Cin  input  1  carry-in; sampled on accepted start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; result valid
Sum  output  WIDTH  registered result; held until next done
Cout  output  1  registered final carry; held until next done

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, Sum=0, Cout=0. Internal registers (operand shift regs, carry reg, bit counter) are all 0.
- FSM states:
  - IDLE: on start=1, load a_sr<=A, b_sr<=B, c<=Cin, cnt<=0, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge, s = a_sr[0]^b_sr[0]^c and c <= (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0])), both computed by the two-Half_Adder slice. a_sr and b_sr shift right with MSB fill 0. s shifts into the MSB of s_sr, which shifts right. cnt increments. When cnt==WIDTH-1, this is the last bit: Sum <= {s, s_sr[WIDTH-1:1]}, Cout <= carry-out of this bit, go to DONE.
  - DONE: done=1 for exactly this one cycle, then unconditional return to IDLE.
- Outputs are Moore-decoded: busy=(state==SHIFT), done=(state==DONE).
- Latency: start sampled at edge k. done is high in the cycle after edge k+WIDTH. Next start can be accepted at edge k+WIDTH+2.
- Sum and Cout change only at the edge entering DONE. They stay stable through subsequent operations until the next DONE.
- start while in SHIFT or DONE is ignored, with no queuing. A, B and Cin are don't-care outside the accepting edge.
- Counter width is clog2(WIDTH+1). WIDTH=1 gives one SHIFT cycle.
- Overflow: the result is mod 2^WIDTH. Carry out of the MSB goes to Cout only.
- rst_n=0 in any state, including mid-SHIFT, aborts the operation and forces all reset values at that edge. A start in the same cycle as rst_n=0 is dropped.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port Sub (1 bit), sampled with start. When Sub=1, b_sr is loaded with ~B and the carry register with 1, so Cin is ignored. Result is Sum=A-B mod 2^WIDTH, with Cout=1 meaning no borrow (A>=B unsigned). When Sub=0, behaviour is identical to the base addition.
- Undefined: Sub port absent; addition only.

Test Plan:
1. WIDTH=8, start with A=8'h3C, B=8'h42, Cin=0 -> busy high 8 cycles; done high exactly 9 edges after the start edge; Sum=8'h7E, Cout=0.
2. A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
3. After a result of 8'h7E, start A=8'h10, B=8'h20 and pulse start again mid-SHIFT with A=8'hAA -> second pulse ignored; Sum stays 8'h7E until done, then becomes 8'h30.
4. rst_n=0 for one cycle during the 4th SHIFT cycle -> next cycle busy=0, done=0, Sum=0, Cout=0; no done pulse appears; a following start with A=8'h01, B=8'h01 gives Sum=8'h02.
5. WIDTH=1: A=1, B=1, Cin=1 -> busy 1 cycle; Sum=1, Cout=1; done 2 edges after start.
6. With SERIAL_ADDER_SUB_EN: A=8'h05, B=8'h07, Sub=1 -> Sum=8'hFE, Cout=0. A=8'h07, B=8'h05, Sub=1 -> Sum=8'h02, Cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Purpose:
//   Bit-serial adder. Two WIDTH-bit operands are captured on a start pulse
//   and added LSB-first, one bit per clock, through a one-bit full-adder
//   slice built from two Half_Adder cells and an OR gate. The carry is held
//   in a register between bits. On the last bit the assembled sum and the
//   final carry are registered and a one-cycle done pulse is raised.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   Adds input Sub. With Sub=1 the B operand is loaded inverted and the
//   carry register is seeded with 1, giving Sum = A - B mod 2^WIDTH and
//   Cout = 1 when no borrow occurred (A >= B unsigned).
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   A      in   WIDTH  operand A, sampled on accepted start
//   B      in   WIDTH  operand B, sampled on accepted start
//   Cin    in   1      carry-in, sampled on accepted start
//   Sub    in   1      subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, Sum/Cout just updated
//   Sum    out  WIDTH  registered result, held until next done
//   Cout   out  1      registered final carry, held until next done
// ---------------------------------------------------------------------------

module Half_Adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c;
    logic [CNT_W-1:0] cnt;

    // Full-adder slice: first cell adds the operand bits, second folds in
    // the carry; a carry can come from either cell but never both.
    logic p, g0, g1, s_bit, c_next;

    Half_Adder ha_op (
        .a (a_sr[0]),
        .b (b_sr[0]),
        .s (p),
        .c (g0)
    );

    Half_Adder ha_cy (
        .a (p),
        .b (c),
        .s (s_bit),
        .c (g1)
    );

    assign c_next = g0 | g1;

    logic last_bit;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH bits the LSB has arrived
    // at position 0. Written this way so WIDTH=1 needs no special case.
    logic [WIDTH-1:0] s_shifted;
    always_comb begin
        s_shifted            = s_sr >> 1;
        s_shifted[WIDTH-1]   = s_bit;
    end

    // Operand load values (subtract = add inverted B with carry-in 1).
    logic [WIDTH-1:0] b_load;
    logic             c_load;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = Sub ? ~B : B;
    assign c_load = Sub ? 1'b1 : Cin;
`else
    assign b_load = B;
    assign c_load = Cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            s_sr <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= b_load;
                        c    <= c_load;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_shifted;
                    c    <= c_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        Sum  <= s_shifted;
                        Cout <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8, sub1;
`endif

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .Sum   (sum8),
        .Cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .Sum   (sum1),
        .Cout  (cout1)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] held8;
    logic [8:0] e8m;
    logic [1:0] e1m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sub);
        logic [7:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + 9'(cin);
    endfunction

    function automatic logic [1:0] model1(input logic a, input logic b,
                                          input logic cin, input logic sub);
        if (sub) return {(a >= b), a ^ b};
        return 2'(a) + 2'(b) + 2'(cin);
    endfunction

    // Scoreboard monitors: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL done8_unexpected: got done=1 expected no pulse at %0t", $time);
            end else begin
                e8m = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(e8m[7:0]));
                chk("cout8", 32'(cout8), 32'(e8m[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL done1_unexpected: got done=1 expected no pulse at %0t", $time);
            end else begin
                e1m = q1.pop_front();
                chk("sum1", 32'(sum1), 32'(e1m[0]));
                chk("cout1", 32'(cout1), 32'(e1m[1]));
            end
        end
    end

    // mode 0: plain op; 1: second start pulse mid-SHIFT; 2: reset in 4th SHIFT cycle
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input int mode);
        int done_n, dcount, bcount;
        logic [8:0] e;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = sub;
`endif
        e = model8(a, b, cin, sub);
        q8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'($urandom);
`endif
        done_n = 0; dcount = 0; bcount = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (done8) begin dcount++; done_n = n; end
            if (busy8) bcount++;
            if (n <= 8) chk("hold8", 32'({cout8, sum8}), 32'(held8));
            if (n >= 10 && mode != 2) chk("after8", 32'({cout8, sum8}), 32'(e));
            if (mode == 2 && n == 4) begin
                rst_n = 1'b0;
                held8 = 9'd0;
                void'(q8.pop_back());
            end
            if (mode == 2 && n == 5) begin
                chk("rst_busy", 32'(busy8), 32'd0);
                chk("rst_done", 32'(done8), 32'd0);
                rst_n = 1'b1;
            end
            if (mode == 1 && n == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'($urandom); end
            if (mode == 1 && n == 4) start8 = 1'b0;
        end
        if (mode == 2) begin
            chk("no_done_after_rst", 32'(dcount), 32'd0);
        end else begin
            chk("done_latency8", 32'(done_n), 32'd9);
            chk("done_width8", 32'(dcount), 32'd1);
            chk("busy_cycles8", 32'(bcount), 32'd8);
            held8 = e;
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic cin, input logic sub);
        int done_n, dcount, bcount;
        @(posedge clk); #1;
        start1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub1 = sub;
`endif
        q1.push_back(model1(a, b, cin, sub));
        @(posedge clk); #1;
        start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
        done_n = 0; dcount = 0; bcount = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (done1) begin dcount++; done_n = n; end
            if (busy1) bcount++;
        end
        chk("done_latency1", 32'(done_n), 32'd2);
        chk("done_width1", 32'(dcount), 32'd1);
        chk("busy_cycles1", 32'(bcount), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0; sub1 = 1'b0;
`endif
        held8 = 9'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy8", 32'(busy8), 32'd0);
        chk("reset_done8", 32'(done8), 32'd0);
        chk("reset_sum8", 32'(sum8), 32'd0);
        chk("reset_cout8", 32'(cout8), 32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);
        chk("reset_sum1", 32'({cout1, sum1}), 32'd0);
        rst_n = 1'b1;

        op8(8'h3C, 8'h42, 1'b0, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        op8(8'h3C, 8'h42, 1'b0, 1'b0, 0);
        op8(8'h10, 8'h20, 1'b0, 1'b0, 1);
        op8(8'h55, 8'h66, 1'b1, 1'b0, 2);
        op8(8'h01, 8'h01, 1'b0, 1'b0, 0);

        op1(1'b1, 1'b1, 1'b1, 1'b0);
        op1(1'b0, 1'b1, 1'b0, 1'b0);
        op1(1'b1, 1'b0, 1'b1, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h05, 8'h07, 1'b0, 1'b1, 0);
        op8(8'h07, 8'h05, 1'b1, 1'b1, 0);
        op8(8'h05, 8'h05, 1'b0, 1'b1, 0);
        op1(1'b0, 1'b1, 1'b1, 1'b1);
        op1(1'b1, 1'b1, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
`else
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);
`endif
        end
        for (int i = 0; i < 6; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            op1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`else
            op1(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
`endif
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
